// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder behind the core MEM-stage port.
// Word-organised RAM with byte-lane writes and a fixed wait-state count
// (LATENCY) before the single-cycle response pulse.
// Optional feature: define DMEM_MMIO_EN to map the upper address half onto
// a tohost register instead of RAM.
module dmem_responder #(
   parameter int WIDTH   = 32,
   parameter int DADDR   = 10,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [DADDR-1:0] req_addr,
   input  logic [3:0]       req_wr_en,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             rsp_err
`ifdef DMEM_MMIO_EN
   ,
   output logic [WIDTH-1:0] tohost
`endif
);
   localparam int         IW    = DADDR - 2;
   localparam int         DEPTH = 2 ** IW;
   localparam logic [3:0] LAT   = 4'(LATENCY);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
   typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_MMIO} src_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             load_q, load_d;       // accepted request is a legal load
   logic             err_q, err_d;         // accepted request had illegal enables
   logic             mmio_q, mmio_d;       // accepted request targets tohost
   src_t             src_q, src_d;         // where rsp_rdata comes from
   logic             rsp_err_q, rsp_err_d;
   logic [WIDTH-1:0] mmio_rdata_q, mmio_rdata_d;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] ram_rdata_q;

   logic             accept;
   logic             req_legal;
   logic             req_load;
   logic             req_mmio;
   logic             ram_we;
   logic             enter_resp;
   logic             cur_load, cur_err, cur_mmio;
   logic [IW-1:0]    cur_idx;
   logic [WIDTH-1:0] tohost_cur;

   // Byte offset bits only matter to the core; lanes come from req_wr_en.
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr[1:0];

   assign req_ready = (state_q == ST_IDLE) & ~reset;
   assign accept    = req_valid & req_ready;
   assign req_load  = (req_wr_en == 4'b0000);
   assign ram_we    = accept & req_legal & ~req_load & ~req_mmio;

   // Only single bytes, aligned halves and full words are accepted.
   always_comb begin
      req_legal = 1'b0;
      case (req_wr_en)
         4'b0000, 4'b0001, 4'b0010, 4'b0100,
         4'b1000, 4'b0011, 4'b1100, 4'b1111: req_legal = 1'b1;
         default:                            req_legal = 1'b0;
      endcase
   end

   // The transaction being answered: live inputs in IDLE (zero latency), latched copy otherwise.
   always_comb begin
      if (state_q == ST_IDLE) begin
         cur_idx  = req_addr[DADDR-1:2];
         cur_load = req_load & req_legal;
         cur_err  = ~req_legal;
         cur_mmio = req_mmio;
      end else begin
         cur_idx  = idx_q;
         cur_load = load_q;
         cur_err  = err_q;
         cur_mmio = mmio_q;
      end
   end

   // FSM next state, wait counter and request latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      load_d     = load_q;
      err_d      = err_q;
      mmio_d     = mmio_q;
      enter_resp = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               idx_d  = req_addr[DADDR-1:2];
               load_d = req_load & req_legal;
               err_d  = ~req_legal;
               mmio_d = req_mmio;
               if (LATENCY == 0) begin
                  state_d    = ST_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'd1;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == LAT) begin
               state_d    = ST_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Response source and error flag are captured on entry to RESP and held afterwards.
   always_comb begin
      src_d        = src_q;
      rsp_err_d    = rsp_err_q;
      mmio_rdata_d = mmio_rdata_q;
      if (enter_resp) begin
         rsp_err_d = cur_err;
         if (!cur_load) begin
            src_d = SRC_ZERO;
         end else if (cur_mmio) begin
            src_d        = SRC_MMIO;
            mmio_rdata_d = tohost_cur;
         end else begin
            src_d = SRC_RAM;
         end
      end
   end

   // Control and response registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         idx_q        <= '0;
         load_q       <= 1'b0;
         err_q        <= 1'b0;
         mmio_q       <= 1'b0;
         src_q        <= SRC_ZERO;
         rsp_err_q    <= 1'b0;
         mmio_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         load_q       <= load_d;
         err_q        <= err_d;
         mmio_q       <= mmio_d;
         src_q        <= src_d;
         rsp_err_q    <= rsp_err_d;
         mmio_rdata_q <= mmio_rdata_d;
      end
   end

   // RAM: byte-lane writes at accept, registered read on entry to RESP.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (req_wr_en[b]) mem[req_addr[DADDR-1:2]][b*8 +: 8] <= req_wdata[b*8 +: 8];
         end
      end
      if (enter_resp) ram_rdata_q <= mem[cur_idx];
   end

`ifdef DMEM_MMIO_EN
   logic [WIDTH-1:0] tohost_q, tohost_d;
   logic [WIDTH-1:0] lane_mask;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_mask[gi*8 +: 8] = {8{req_wr_en[gi]}};
   end

   assign req_mmio   = req_addr[DADDR-1];
   assign tohost_cur = tohost_q;
   assign tohost     = tohost_q;

   // Stores to the upper half merge lanes into tohost.
   always_comb begin
      tohost_d = tohost_q;
      if (accept & req_legal & ~req_load & req_mmio)
         tohost_d = (tohost_q & ~lane_mask) | (req_wdata & lane_mask);
   end

   // tohost register.
   always_ff @(posedge clk) begin
      if (reset) tohost_q <= '0;
      else       tohost_q <= tohost_d;
   end
`else
   assign req_mmio   = 1'b0;
   assign tohost_cur = '0;
`endif

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = (src_q == SRC_RAM)  ? ram_rdata_q  :
                      (src_q == SRC_MMIO) ? mmio_rdata_q : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with LATENCY=1 for data
// checks, one with LATENCY=3 for back-to-back timing. Define DMEM_MMIO_EN
// to also exercise the tohost register.
module tb_dmem_responder;
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, rst3, v1, v3;
   logic [9:0]  a1, a3;
   logic [3:0]  we1, we3;
   logic [31:0] wd1, wd3;
   logic        rdy1, rdy3, rv1, rv3, er1, er3;
   logic [31:0] rd1, rd3;
`ifdef DMEM_MMIO_EN
   logic [31:0] th1, th3;
   localparam logic [9:0] TOP_A = 10'h1FC;
`else
   localparam logic [9:0] TOP_A = 10'h3FC;
`endif

   int tests  = 0;
   int failed = 0;

   dmem_responder #(.WIDTH(32), .DADDR(10), .LATENCY(1)) u_dut1 (
      .clk(clk), .reset(rst1), .req_valid(v1), .req_ready(rdy1), .req_addr(a1),
      .req_wr_en(we1), .req_wdata(wd1), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(er1)
`ifdef DMEM_MMIO_EN
      , .tohost(th1)
`endif
   );

   dmem_responder #(.WIDTH(32), .DADDR(10), .LATENCY(3)) u_dut3 (
      .clk(clk), .reset(rst3), .req_valid(v3), .req_ready(rdy3), .req_addr(a3),
      .req_wr_en(we3), .req_wdata(wd3), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(er3)
`ifdef DMEM_MMIO_EN
      , .tohost(th3)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit d3, input logic v, input logic [9:0] a,
                        input logic [3:0] we, input logic [31:0] wd);
      if (d3) begin v3 = v; a3 = a; we3 = we; wd3 = wd; end
      else    begin v1 = v; a1 = a; we1 = we; wd1 = wd; end
   endtask

   // Wait (bounded) at negedges until the chosen DUT is ready, then pass the accepting edge.
   task automatic wait_accept(input bit d3, input string tag);
      int guard = 0;
      while (!(d3 ? rdy3 : rdy1) && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
      @(posedge clk);
      @(negedge clk);
      drive(d3, 1'b0, 10'h3FF, 4'hF, 32'hFFFF_FFFF);
   endtask

   task automatic txn(input bit d3, input logic [9:0] addr, input logic [3:0] we,
                      input logic [31:0] wd, input string tag,
                      output logic [31:0] rd, output logic er, output int lat);
      drive(d3, 1'b1, addr, we, wd);
      wait_accept(d3, tag);
      lat = 1;
      while (!(d3 ? rv3 : rv1) && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      rd = d3 ? rd3 : rd1;
      er = d3 ? er3 : er1;
      $display("[TB] %s dut%0d addr=%h we=%b wd=%h -> rdata=%h err=%0d lat=%0d",
               tag, d3 ? 3 : 1, addr, we, wd, rd, er, lat);
   endtask

   task automatic do_chk(input bit d3, input logic [9:0] addr, input logic [3:0] we,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err, input string tag);
      logic [31:0] rd;
      logic        er;
      int          lat;
      txn(d3, addr, we, wd, tag, rd, er, lat);
      check({tag, "_rdata"}, rd, exp_rd);
      check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
      check({tag, "_lat"}, lat, d3 ? 32'd4 : 32'd2);
   endtask

   // Accept a request, then reset while it waits; no response may follow.
   task automatic txn_reset(input logic [9:0] addr, input logic [3:0] we,
                            input logic [31:0] wd, input string tag);
      int pulses;
      drive(1'b0, 1'b1, addr, we, wd);
      wait_accept(1'b0, tag);
      rst1 = 1'b1;
      @(negedge clk);
      check({tag, "_rdy_in_rst"}, {31'd0, rdy1}, 32'd0);
      pulses = rv1 ? 1 : 0;
      rst1 = 1'b0;
      @(negedge clk);
      check({tag, "_rdy_after_rst"}, {31'd0, rdy1}, 32'd1);
      repeat (5) begin
         if (rv1) pulses++;
         @(negedge clk);
      end
      check({tag, "_no_rsp"}, pulses, 32'd0);
      $display("[TB] %s dut1 addr=%h we=%b wd=%h reset in WAIT, pulses=%0d", tag, addr, we, wd, pulses);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc, n_acc, n_rsp, low_cnt;
      int acc_cyc[3];
      int rsp_cyc[3];

      rst1 = 1'b1; rst3 = 1'b1;
      drive(1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
      drive(1'b1, 1'b0, 10'h0, 4'h0, 32'h0);
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, rdy1}, 32'd0);
      check("rst_valid", {31'd0, rv1}, 32'd0);
      check("rst_rdata", rd1, 32'd0);
      check("rst_err",   {31'd0, er1}, 32'd0);
`ifdef DMEM_MMIO_EN
      check("rst_tohost", th1, 32'd0);
`endif
      rst1 = 1'b0; rst3 = 1'b0;
      @(negedge clk);
      check("post_rst_ready1", {31'd0, rdy1}, 32'd1);
      check("post_rst_ready3", {31'd0, rdy3}, 32'd1);
      check("post_rst_valid",  {31'd0, rv1}, 32'd0);

      // Full-word store and load back.
      do_chk(0, 10'h010, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, "st_word");
      do_chk(0, 10'h010, 4'b0000, 32'h0,         32'hDEAD_BEEF, 1'b0, "ld_word");
      // Partial-lane stores; low address bits ignored on the load.
      do_chk(0, 10'h010, 4'b0001, 32'h0000_00AB, 32'h0,         1'b0, "st_b0");
      do_chk(0, 10'h013, 4'b0000, 32'h0,         32'hDEAD_BEAB, 1'b0, "ld_b0");
      do_chk(0, 10'h010, 4'b1100, 32'h1234_0000, 32'h0,         1'b0, "st_hi");
      do_chk(0, 10'h010, 4'b0000, 32'h0,         32'h1234_BEAB, 1'b0, "ld_hi");
      do_chk(0, 10'h010, 4'b0010, 32'h0000_5600, 32'h0,         1'b0, "st_b1");
      do_chk(0, 10'h010, 4'b1000, 32'h9900_0000, 32'h0,         1'b0, "st_b3");
      do_chk(0, 10'h012, 4'b0000, 32'h0,         32'h9934_56AB, 1'b0, "ld_b13");
      do_chk(0, 10'h014, 4'b1111, 32'h0000_0000, 32'h0,         1'b0, "st_clr");
      do_chk(0, 10'h014, 4'b0011, 32'hFFFF_CDEF, 32'h0,         1'b0, "st_lo");
      do_chk(0, 10'h014, 4'b0100, 32'h0077_0000, 32'h0,         1'b0, "st_b2");
      do_chk(0, 10'h016, 4'b0000, 32'h0,         32'h0077_CDEF, 1'b0, "ld_lo_b2");
      // Illegal enables write nothing and flag an error.
      do_chk(0, 10'h020, 4'b1111, 32'hCAFE_F00D, 32'h0,         1'b0, "st_ref");
      do_chk(0, 10'h020, 4'b0101, 32'hFFFF_FFFF, 32'h0,         1'b1, "st_0101");
      do_chk(0, 10'h020, 4'b1110, 32'hFFFF_FFFF, 32'h0,         1'b1, "st_1110");
      do_chk(0, 10'h020, 4'b0000, 32'h0,         32'hCAFE_F00D, 1'b0, "ld_after_err");
      // Lowest and highest RAM words, no aliasing.
      do_chk(0, 10'h000, 4'b1111, 32'h0BAD_C0DE, 32'h0,         1'b0, "st_w0");
      do_chk(0, TOP_A,   4'b1111, 32'h55AA_1234, 32'h0,         1'b0, "st_top");
      do_chk(0, TOP_A | 10'h3, 4'b0000, 32'h0,   32'h55AA_1234, 1'b0, "ld_top");
      do_chk(0, 10'h000, 4'b0000, 32'h0,         32'h0BAD_C0DE, 1'b0, "ld_w0");
      // Response data holds after the pulse.
      @(negedge clk);
      check("hold_valid", {31'd0, rv1}, 32'd0);
      check("hold_rdata", rd1, 32'h0BAD_C0DE);

      // Reset during a pending load, then during a pending store.
      txn_reset(10'h010, 4'b0000, 32'h0, "rst_ld");
      do_chk(0, 10'h010, 4'b0000, 32'h0,         32'h9934_56AB, 1'b0, "ld_post_rst");
      txn_reset(10'h030, 4'b1111, 32'h1357_2468, "rst_st");
      do_chk(0, 10'h030, 4'b0000, 32'h0,         32'h1357_2468, 1'b0, "ld_committed");

`ifdef DMEM_MMIO_EN
      do_chk(0, 10'h200, 4'b1111, 32'h0000_0001, 32'h0,         1'b0, "mmio_st");
      check("mmio_tohost", th1, 32'h0000_0001);
      do_chk(0, 10'h000, 4'b0000, 32'h0,         32'h0BAD_C0DE, 1'b0, "mmio_ram0");
      do_chk(0, 10'h200, 4'b0000, 32'h0,         32'h0000_0001, 1'b0, "mmio_ld");
      do_chk(0, 10'h204, 4'b0010, 32'h0000_AB00, 32'h0,         1'b0, "mmio_st_b1");
      check("mmio_tohost_b1", th1, 32'h0000_AB01);
`endif

      // LATENCY=3 with req_valid held: three stores back-to-back.
      foreach (acc_cyc[i]) begin acc_cyc[i] = 0; rsp_cyc[i] = 0; end
      drive(1'b1, 1'b1, 10'h040, 4'b1111, 32'h1111_2222);
      cyc = 0; n_acc = 0; n_rsp = 0; low_cnt = 0;
      while (n_rsp < 3 && cyc < 60) begin
         if (rv3 && n_rsp < 3) begin rsp_cyc[n_rsp] = cyc; n_rsp++; end
         if (n_acc > 0 && !rdy3) low_cnt++;
         if (rdy3 && v3 && n_acc < 3) begin acc_cyc[n_acc] = cyc; n_acc++; end
         @(negedge clk);
         cyc++;
         if (n_acc == 3) v3 = 1'b0;
      end
      $display("[TB] b2b dut3 accepts=%0d rsps=%0d acc=%0d,%0d,%0d rsp=%0d,%0d,%0d low=%0d",
               n_acc, n_rsp, acc_cyc[0], acc_cyc[1], acc_cyc[2],
               rsp_cyc[0], rsp_cyc[1], rsp_cyc[2], low_cnt);
      check("b2b_accepts", n_acc, 32'd3);
      check("b2b_rsps",    n_rsp, 32'd3);
      check("b2b_acc_gap1", acc_cyc[1] - acc_cyc[0], 32'd5);
      check("b2b_acc_gap2", acc_cyc[2] - acc_cyc[1], 32'd5);
      check("b2b_lat0", rsp_cyc[0] - acc_cyc[0], 32'd4);
      check("b2b_lat1", rsp_cyc[1] - acc_cyc[1], 32'd4);
      check("b2b_lat2", rsp_cyc[2] - acc_cyc[2], 32'd4);
      check("b2b_ready_low", low_cnt, 32'd12);
      do_chk(1, 10'h040, 4'b0000, 32'h0, 32'h1111_2222, 1'b0, "ld_lat3");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
